// File: rtl/rv_plic_mt_pkg.sv
// rv_plic_mt_pkg: shared gateway state type and width helpers for the multi-target PLIC core
package rv_plic_mt_pkg;
  typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_CLAIMED} gw_state_e;
  function automatic int id_width(input int n_src);
    return $clog2(n_src + 1);
  endfunction
  function automatic int prio_width(input int max_prio);
    return $clog2(max_prio + 1);
  endfunction
endpackage

// File: rtl/rv_plic_mt_gateway.sv
// rv_plic_mt_gateway: per-source gateway FSM with edge detect and saturating edge-event counter
module rv_plic_mt_gateway import rv_plic_mt_pkg::*; #(
  parameter int CNT_W = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic le_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  gw_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0] sum;
  logic src_q, rise;
  assign rise = src_i & ~src_q;
  assign sum = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rise};
  assign ip_o = state_q == GW_PEND;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (rise && state_q != GW_IDLE && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      GW_IDLE: state_d = (le_i ? rise : src_i) ? GW_PEND : GW_IDLE;
      GW_PEND: state_d = claim_i ? GW_CLAIMED : GW_PEND;
      GW_CLAIMED: if (complete_i) begin
        // a completed edge source re-pends while any counted edges remain
        state_d = (le_i && |sum) ? GW_PEND : GW_IDLE;
        cnt_d = (le_i && |sum) ? CNT_W'(sum - (CNT_W+1)'(1)) : '0;
      end
      default: state_d = GW_IDLE;
    endcase
    if (!le_i) cnt_d = '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= GW_IDLE;
      cnt_q <= '0;
      src_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      src_q <= src_i;
    end
  end
endmodule

// File: rtl/rv_plic_core_mt.sv
// rv_plic_core_mt: multi-target PLIC core with per-target arbitration and claim/complete handling
module rv_plic_core_mt import rv_plic_mt_pkg::*; #(
  parameter int N_SRC = 32,
  parameter int N_TGT = 2,
  parameter int MAX_PRIO = 7,
  parameter int EDGE_CNT_W = 2,
  parameter int IDW = id_width(N_SRC),
  parameter int PRIOW = prio_width(MAX_PRIO)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_SRC-1:0]       intr_src_i,
  input  logic [N_SRC-1:0]       le_i,
  input  logic [N_SRC*PRIOW-1:0] prio_i,
  input  logic [N_TGT*N_SRC-1:0] ie_i,
  input  logic [N_TGT*PRIOW-1:0] threshold_i,
  input  logic [N_TGT-1:0]       claim_i,
  input  logic [N_TGT-1:0]       complete_i,
  input  logic [N_TGT*IDW-1:0]   complete_id_i,
  output logic [N_SRC-1:0]       ip_o,
  output logic [N_TGT-1:0]       irq_o,
  output logic [N_TGT*IDW-1:0]   irq_id_o,
  output logic [N_TGT*IDW-1:0]   claim_id_o
);
  logic [N_SRC-1:0] src_claim, src_complete;
  logic [N_TGT-1:0] irq_d;
  logic [N_TGT*IDW-1:0] irq_id_d;
  logic [PRIOW-1:0] best_prio [N_TGT];
  logic [IDW-1:0] best_id [N_TGT];
  for (genvar g = 0; g < N_SRC; g++) begin : g_gw
    rv_plic_mt_gateway #(.CNT_W(EDGE_CNT_W)) u_gw (
      .clk_i(clk_i), .rst_i(rst_i), .src_i(intr_src_i[g]), .le_i(le_i[g]),
      .claim_i(src_claim[g]), .complete_i(src_complete[g]), .ip_o(ip_o[g])
    );
  end
  // strict '>' from a zero start excludes priority 0 and keeps the lowest ID on ties
  always_comb begin
    irq_d = '0;
    irq_id_d = '0;
    for (int t = 0; t < N_TGT; t++) begin
      best_prio[t] = '0;
      best_id[t] = '0;
      for (int s = 0; s < N_SRC; s++)
        if (ip_o[s] && ie_i[t*N_SRC+s] && prio_i[s*PRIOW +: PRIOW] > best_prio[t]) begin
          best_prio[t] = prio_i[s*PRIOW +: PRIOW];
          best_id[t] = IDW'(s + 1);
        end
      irq_d[t] = best_prio[t] > threshold_i[t*PRIOW +: PRIOW];
      irq_id_d[t*IDW +: IDW] = irq_d[t] ? best_id[t] : '0;
    end
  end
  // targets scanned in index order so a lower target's grant blocks higher ones
  always_comb begin
    claim_id_o = '0;
    src_claim = '0;
    src_complete = '0;
    for (int t = 0; t < N_TGT; t++)
      for (int s = 0; s < N_SRC; s++) begin
        if (claim_i[t] && irq_id_o[t*IDW +: IDW] == IDW'(s + 1) && ip_o[s] && !src_claim[s]) begin
          src_claim[s] = 1'b1;
          claim_id_o[t*IDW +: IDW] = IDW'(s + 1);
        end
        if (complete_i[t] && complete_id_i[t*IDW +: IDW] == IDW'(s + 1)) src_complete[s] = 1'b1;
      end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o <= '0;
      irq_id_o <= '0;
    end else begin
      irq_o <= irq_d;
      irq_id_o <= irq_id_d;
    end
  end
endmodule
